// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode, requester id and arbiter state.
// Imported by the interface, the picker and the arbiter top.
package alu_arbiter_pkg;

    localparam int NUM_REQ  = 2;
    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_NOT   = 3'd5,
        ALU_PASSA = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_t;

    typedef logic req_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Grants are one-hot over two requesters, so the id is simply the upper bit.
    function automatic req_id_t grantToId(input logic [NUM_REQ-1:0] grant);
        return req_id_t'(grant[1]);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals around the ALU arbiter.
// The arbiter sits on the slave modport; requesters, ALU and consumer on the master side.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 32
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_a;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ic;
    logic [NUM_REQ*OP_WIDTH-1:0]   req_opcode;
    logic [NUM_REQ-1:0]            req_lock;

    logic [WORD_WIDTH-1:0]         alu_a;
    logic [WORD_WIDTH-1:0]         alu_b;
    logic                          alu_ic;
    alu_op_t                       alu_opcode;
    logic [WORD_WIDTH-1:0]         alu_out;
    logic                          alu_oc;

    logic                          rsp_valid;
    logic                          rsp_ready;
    req_id_t                       rsp_id;
    logic [WORD_WIDTH-1:0]         rsp_result;
    logic                          rsp_carry;

    modport slave (
        input  req_valid, req_a, req_b, req_ic, req_opcode, req_lock,
        input  alu_out, alu_oc, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ic, alu_opcode,
        output rsp_valid, rsp_id, rsp_result, rsp_carry
    );

    modport master (
        output req_valid, req_a, req_b, req_ic, req_opcode, req_lock,
        output alu_out, alu_oc, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ic, alu_opcode,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry
    );

endinterface

// File: rtl/alu_arbiter_pick2.sv
// Combinational two-way picker: one-hot grant among valid requesters,
// with the prio bit deciding which requester wins when both are valid.
module arb_pick2 (
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = i_prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one op per cycle, with grant locking
// for carry chains and a one-entry response buffer. Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input logic          clk,
    input logic          reset_n,
    alu_arbiter_if.slave bus
);

    arb_state_e            r_state;
    req_id_t               r_owner;
    logic                  r_rspValid;
    req_id_t               r_rspId;
    logic [WORD_WIDTH-1:0] r_rspResult;
    logic                  r_rspCarry;

    logic                  w_slotFree;
    logic                  w_prio;
    logic [NUM_REQ-1:0]    w_pick;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_accept;
    req_id_t               w_gntId;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    req_id_t r_rrPtr;
    assign w_prio = r_rrPtr;
`else
    assign w_prio = 1'b0;
`endif

    assign w_slotFree = !r_rspValid || bus.rsp_ready;

    arb_pick2 u_pick (
        .i_valid (bus.req_valid),
        .i_prio  (w_prio),
        .o_grant (w_pick)
    );

    // A locked owner keeps exclusive access even on cycles where it presents nothing.
    always_comb begin
        w_ready = '0;
        if (reset_n && w_slotFree) begin
            if (r_state == LOCKED) begin
                w_ready[r_owner] = bus.req_valid[r_owner];
            end else begin
                w_ready = w_pick;
            end
        end
    end

    assign w_accept = |(bus.req_valid & w_ready);
    assign w_gntId  = grantToId(w_ready);

    always_comb begin
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_ic     = 1'b0;
        bus.alu_opcode = ALU_ADD;
        if (w_accept) begin
            if (w_gntId) begin
                bus.alu_a      = bus.req_a[2*WORD_WIDTH-1:WORD_WIDTH];
                bus.alu_b      = bus.req_b[2*WORD_WIDTH-1:WORD_WIDTH];
                bus.alu_ic     = bus.req_ic[1];
                bus.alu_opcode = alu_op_t'(bus.req_opcode[2*OP_WIDTH-1:OP_WIDTH]);
            end else begin
                bus.alu_a      = bus.req_a[WORD_WIDTH-1:0];
                bus.alu_b      = bus.req_b[WORD_WIDTH-1:0];
                bus.alu_ic     = bus.req_ic[0];
                bus.alu_opcode = alu_op_t'(bus.req_opcode[OP_WIDTH-1:0]);
            end
        end
    end

    // A same-cycle accept and consume simply overwrites the buffer, so it stays valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_rspValid  <= 1'b0;
            r_rspId     <= 1'b0;
            r_rspResult <= '0;
            r_rspCarry  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rspValid  <= 1'b1;
                r_rspId     <= w_gntId;
                r_rspResult <= bus.alu_out;
                r_rspCarry  <= bus.alu_oc;
                r_owner     <= w_gntId;
                r_state     <= bus.req_lock[w_gntId] ? LOCKED : IDLE;
            end else if (bus.rsp_ready) begin
                r_rspValid  <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Favour the loser only once a chain has ended, so locks never disturb fairness.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rrPtr <= 1'b0;
        end else if (w_accept && !bus.req_lock[w_gntId]) begin
            r_rrPtr <= !w_gntId;
        end
    end
`endif

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = r_rspValid;
    assign bus.rsp_id     = r_rspId;
    assign bus.rsp_result = r_rspResult;
    assign bus.rsp_carry  = r_rspCarry;

endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter with a behavioural ALU and a response scoreboard.
// Expected grants follow the build: fixed priority by default, round-robin with ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int WW = 32;

    typedef struct {
        string          name;
        logic [1:0]     valid;
        logic [1:0]     lock;
        logic [WW-1:0]  a0;
        logic [WW-1:0]  b0;
        logic           ic0;
        alu_op_t        op0;
        logic [WW-1:0]  a1;
        logic [WW-1:0]  b1;
        logic           ic1;
        alu_op_t        op1;
        logic           rspReady;
        logic [1:0]     expReady;
        logic [WW-1:0]  expResult;
        logic           expCarry;
    } vec_t;

    typedef struct {
        logic           id;
        logic [WW-1:0]  result;
        logic           carry;
    } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;
    vec_t vecs[$];
    rsp_t sbQ[$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.WORD_WIDTH(WW)) bus ();

    alu_arbiter #(.WORD_WIDTH(WW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural ALU; SUB reports a borrow in the carry-out.
    function automatic logic [WW:0] aluRef(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                           input logic ic, input alu_op_t op);
        case (op)
            ALU_ADD:   return {1'b0, a} + {1'b0, b} + {{WW{1'b0}}, ic};
            ALU_SUB:   return {1'b0, a} - {1'b0, b} - {{WW{1'b0}}, ic};
            ALU_AND:   return {1'b0, a & b};
            ALU_OR:    return {1'b0, a | b};
            ALU_XOR:   return {1'b0, a ^ b};
            ALU_NOT:   return {1'b0, ~a};
            ALU_PASSA: return {1'b0, a};
            default:   return {1'b0, b};
        endcase
    endfunction

    assign {bus.alu_oc, bus.alu_out} = aluRef(bus.alu_a, bus.alu_b, bus.alu_ic, bus.alu_opcode);

    function automatic vec_t mk(input string name, input logic [1:0] valid, input logic [1:0] lock,
                                input logic [WW-1:0] a0, input logic [WW-1:0] b0, input logic ic0,
                                input alu_op_t op0, input logic [WW-1:0] a1, input logic [WW-1:0] b1,
                                input logic ic1, input alu_op_t op1, input logic rspReady,
                                input logic [1:0] expReady, input logic [WW-1:0] expResult,
                                input logic expCarry);
        vec_t v;
        v.name = name;   v.valid = valid; v.lock = lock;
        v.a0 = a0; v.b0 = b0; v.ic0 = ic0; v.op0 = op0;
        v.a1 = a1; v.b1 = b1; v.ic1 = ic1; v.op1 = op1;
        v.rspReady = rspReady; v.expReady = expReady;
        v.expResult = expResult; v.expCarry = expCarry;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Grant and ALU-side checks, taken mid-cycle while the request is held.
    task automatic checkOutput(input vec_t v);
        logic [WW-1:0] expA;
        logic [WW-1:0] expB;
        logic          expIc;
        alu_op_t       expOp;
        expA = '0; expB = '0; expIc = 1'b0; expOp = ALU_ADD;
        if (v.expReady[1]) begin
            expA = v.a1; expB = v.b1; expIc = v.ic1; expOp = v.op1;
        end else if (v.expReady[0]) begin
            expA = v.a0; expB = v.b0; expIc = v.ic0; expOp = v.op0;
        end
        checkVal({v.name, " req_ready"},  64'(bus.req_ready),  64'(v.expReady));
        checkVal({v.name, " alu_a"},      64'(bus.alu_a),      64'(expA));
        checkVal({v.name, " alu_b"},      64'(bus.alu_b),      64'(expB));
        checkVal({v.name, " alu_ic"},     64'(bus.alu_ic),     64'(expIc));
        checkVal({v.name, " alu_opcode"}, 64'(bus.alu_opcode), 64'(expOp));
    endtask

    task automatic checkResponse(input string name);
        if (sbQ.size() > 0) begin
            checkVal({name, " rsp_valid"},  64'(bus.rsp_valid),  64'd1);
            checkVal({name, " rsp_id"},     64'(bus.rsp_id),     64'(sbQ[0].id));
            checkVal({name, " rsp_result"}, 64'(bus.rsp_result), 64'(sbQ[0].result));
            checkVal({name, " rsp_carry"},  64'(bus.rsp_carry),  64'(sbQ[0].carry));
        end else begin
            checkVal({name, " rsp_valid"},  64'(bus.rsp_valid),  64'd0);
        end
    endtask

    // Entered and left at posedge+1; the scoreboard is updated at the edge itself.
    task automatic applyStimulus(input vec_t v);
        bus.req_valid  = v.valid;
        bus.req_lock   = v.lock;
        bus.req_a      = {v.a1, v.a0};
        bus.req_b      = {v.b1, v.b0};
        bus.req_ic     = {v.ic1, v.ic0};
        bus.req_opcode = {v.op1, v.op0};
        bus.rsp_ready  = v.rspReady;
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        if (v.rspReady && sbQ.size() > 0) sbQ.delete(0);
        if (v.expReady != 2'b00) sbQ.push_back('{id: v.expReady[1], result: v.expResult, carry: v.expCarry});
        #1;
        checkResponse(v.name);
    endtask

    initial begin
        vecs.push_back(mk("t1_add", 2'b01, 2'b00, 32'd5, 32'd7, 1'b0, ALU_ADD,
                          32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 2'b01, 32'd12, 1'b0));
`ifdef ALU_ARB_ROUND_ROBIN_EN
        vecs.push_back(mk("t2a", 2'b11, 2'b00, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, ALU_AND,
                          32'hAAAA5555, 32'hFFFF0000, 1'b0, ALU_XOR, 1'b1, 2'b10, 32'h55555555, 1'b0));
        vecs.push_back(mk("t2b", 2'b11, 2'b00, 32'd1, 32'd2, 1'b1, ALU_ADD,
                          32'd10, 32'd3, 1'b0, ALU_SUB, 1'b1, 2'b01, 32'd4, 1'b0));
        vecs.push_back(mk("t2c", 2'b11, 2'b00, 32'hF0, 32'h0F, 1'b0, ALU_OR,
                          32'd0, 32'd1, 1'b0, ALU_SUB, 1'b1, 2'b10, 32'hFFFFFFFF, 1'b1));
`else
        vecs.push_back(mk("t2a", 2'b11, 2'b00, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, ALU_AND,
                          32'hAAAA5555, 32'hFFFF0000, 1'b0, ALU_XOR, 1'b1, 2'b01, 32'h0F000F00, 1'b0));
        vecs.push_back(mk("t2b", 2'b11, 2'b00, 32'd1, 32'd2, 1'b1, ALU_ADD,
                          32'd10, 32'd3, 1'b0, ALU_SUB, 1'b1, 2'b01, 32'd4, 1'b0));
        vecs.push_back(mk("t2c", 2'b11, 2'b00, 32'hF0, 32'h0F, 1'b0, ALU_OR,
                          32'd0, 32'd1, 1'b0, ALU_SUB, 1'b1, 2'b01, 32'hFF, 1'b0));
`endif
        vecs.push_back(mk("t2d", 2'b11, 2'b00, 32'h12345678, 32'd0, 1'b0, ALU_PASSA,
                          32'd0, 32'hCAFEBABE, 1'b0, ALU_PASSB, 1'b1, 2'b01, 32'h12345678, 1'b0));
        vecs.push_back(mk("t3_lock", 2'b10, 2'b10, 32'd5, 32'd7, 1'b0, ALU_ADD,
                          32'hFFFFFFFF, 32'd1, 1'b0, ALU_ADD, 1'b1, 2'b10, 32'd0, 1'b1));
        vecs.push_back(mk("t3_owner_idle", 2'b01, 2'b00, 32'd5, 32'd7, 1'b0, ALU_ADD,
                          32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 2'b00, 32'd0, 1'b0));
        vecs.push_back(mk("t3_chain", 2'b11, 2'b00, 32'd5, 32'd7, 1'b0, ALU_ADD,
                          32'd0, 32'd0, 1'b1, ALU_ADD, 1'b1, 2'b10, 32'd1, 1'b0));
        vecs.push_back(mk("t3_release", 2'b01, 2'b00, 32'd5, 32'd7, 1'b0, ALU_ADD,
                          32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 2'b01, 32'd12, 1'b0));
        vecs.push_back(mk("t4_fill", 2'b01, 2'b00, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, ALU_XOR,
                          32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 2'b01, 32'h0F0F0F0F, 1'b0));
        vecs.push_back(mk("t4_stall1", 2'b11, 2'b00, 32'd100, 32'd1, 1'b1, ALU_SUB,
                          32'd0, 32'd0, 1'b0, ALU_NOT, 1'b0, 2'b00, 32'd0, 1'b0));
        vecs.push_back(mk("t4_stall2", 2'b11, 2'b00, 32'd100, 32'd1, 1'b1, ALU_SUB,
                          32'd0, 32'd0, 1'b0, ALU_NOT, 1'b0, 2'b00, 32'd0, 1'b0));
`ifdef ALU_ARB_ROUND_ROBIN_EN
        vecs.push_back(mk("t4_swap", 2'b11, 2'b00, 32'd100, 32'd1, 1'b1, ALU_SUB,
                          32'd0, 32'd0, 1'b0, ALU_NOT, 1'b1, 2'b10, 32'hFFFFFFFF, 1'b0));
`else
        vecs.push_back(mk("t4_swap", 2'b11, 2'b00, 32'd100, 32'd1, 1'b1, ALU_SUB,
                          32'd0, 32'd0, 1'b0, ALU_NOT, 1'b1, 2'b01, 32'd98, 1'b0));
`endif
        vecs.push_back(mk("t6_idle1", 2'b00, 2'b11, 32'hDEADBEEF, 32'h1234, 1'b1, ALU_SUB,
                          32'hBEEF, 32'h5678, 1'b1, ALU_OR, 1'b1, 2'b00, 32'd0, 1'b0));
        vecs.push_back(mk("t6_idle2", 2'b00, 2'b00, 32'hDEADBEEF, 32'h1234, 1'b1, ALU_SUB,
                          32'hBEEF, 32'h5678, 1'b1, ALU_OR, 1'b1, 2'b00, 32'd0, 1'b0));

        bus.req_valid  = 2'b11;
        bus.req_lock   = 2'b00;
        bus.req_a      = {32'd3, 32'd4};
        bus.req_b      = {32'd5, 32'd6};
        bus.req_ic     = 2'b00;
        bus.req_opcode = {ALU_ADD, ALU_ADD};
        bus.rsp_ready  = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checkVal("reset req_ready",  64'(bus.req_ready),  64'd0);
        checkVal("reset rsp_valid",  64'(bus.rsp_valid),  64'd0);
        checkVal("reset rsp_id",     64'(bus.rsp_id),     64'd0);
        checkVal("reset rsp_result", 64'(bus.rsp_result), 64'd0);
        checkVal("reset rsp_carry",  64'(bus.rsp_carry),  64'd0);
        checkVal("reset alu_a",      64'(bus.alu_a),      64'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset lands while requester 1 holds the lock and its response is unconsumed.
        applyStimulus(mk("t5_lock", 2'b10, 2'b10, 32'd0, 32'd0, 1'b0, ALU_ADD,
                         32'd3, 32'd4, 1'b0, ALU_ADD, 1'b1, 2'b10, 32'd7, 1'b0));
        bus.req_valid = 2'b11;
        bus.req_lock  = 2'b00;
        bus.rsp_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        checkVal("t5 rsp_valid in reset", 64'(bus.rsp_valid),  64'd0);
        checkVal("t5 req_ready in reset", 64'(bus.req_ready),  64'd0);
        checkVal("t5 alu_a in reset",     64'(bus.alu_a),      64'd0);
        checkVal("t5 rsp_result cleared", 64'(bus.rsp_result), 64'd0);
        sbQ.delete();
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(mk("t5_req1_grant", 2'b10, 2'b00, 32'd0, 32'd0, 1'b0, ALU_ADD,
                         32'd9, 32'd6, 1'b0, ALU_SUB, 1'b1, 2'b10, 32'd3, 1'b0));
        applyStimulus(mk("t5_both_idle", 2'b11, 2'b00, 32'hF, 32'h3, 1'b0, ALU_AND,
                         32'd1, 32'd1, 1'b0, ALU_ADD, 1'b1, 2'b01, 32'h3, 1'b0));
        applyStimulus(mk("drain", 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ALU_ADD,
                         32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 2'b00, 32'd0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
